// File: rtl/dpc_pkg.sv
// -----------------------------------------------------------------------------
// dpc_pkg
// Shared definitions for the DekatronPC run-control sequencer:
//   - dpc_state_t : machine state, encoded to match DPC_currentState elsewhere
//                   in the DekatronPC code.
//   - KEY_*       : bit positions of the front-panel keys in a 5-bit vector.
//   - dpc_event_t : one resolved key event per cycle.
//   - dpc_pick_event : resolves several simultaneous key edges by priority
//                   (hard > soft > halt > step > run).
// -----------------------------------------------------------------------------
package dpc_pkg;

  typedef enum logic [2:0] {
    DPC_HARD_RST = 3'b000,
    DPC_SOFT_RST = 3'b001,
    DPC_HALT     = 3'b010,
    DPC_STEP     = 3'b011,
    DPC_RUN      = 3'b100
  } dpc_state_t;

  localparam int unsigned KEY_W        = 5;
  localparam int unsigned KEY_HARD_RST = 0;
  localparam int unsigned KEY_SOFT_RST = 1;
  localparam int unsigned KEY_HALT     = 2;
  localparam int unsigned KEY_STEP     = 3;
  localparam int unsigned KEY_RUN      = 4;

  typedef enum logic [2:0] {
    EV_NONE = 3'd0,
    EV_HARD = 3'd1,
    EV_SOFT = 3'd2,
    EV_HALT = 3'd3,
    EV_STEP = 3'd4,
    EV_RUN  = 3'd5
  } dpc_event_t;

  // Only the highest-priority edge of a cycle is acted upon; lower ones are dropped.
  function automatic dpc_event_t dpc_pick_event(input logic [KEY_W-1:0] edges);
    dpc_event_t ev;
    if (edges[KEY_HARD_RST]) begin
      ev = EV_HARD;
    end else if (edges[KEY_SOFT_RST]) begin
      ev = EV_SOFT;
    end else if (edges[KEY_HALT]) begin
      ev = EV_HALT;
    end else if (edges[KEY_STEP]) begin
      ev = EV_STEP;
    end else if (edges[KEY_RUN]) begin
      ev = EV_RUN;
    end else begin
      ev = EV_NONE;
    end
    return ev;
  endfunction

endpackage

// File: rtl/dpc_key_edge.sv
// -----------------------------------------------------------------------------
// dpc_key_edge
// Rising-edge detector for a vector of already-synchronised key levels.
// The history register resets to all ones, so a key that is held down while
// reset is released does not produce an edge until it is released and pressed
// again.
// Ports:
//   Clk    in            system clock
//   Rst_n  in            asynchronous active-low reset
//   key_i  in  [WIDTH]   key levels
//   edge_o out [WIDTH]   one-cycle pulse per key on a 0->1 transition
// -----------------------------------------------------------------------------
module dpc_key_edge #(
  parameter int unsigned WIDTH = 5
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic [WIDTH-1:0] key_i,
  output logic [WIDTH-1:0] edge_o
);

  logic [WIDTH-1:0] prev_d;
  logic [WIDTH-1:0] prev_q;

  // Next history value is simply the current key level
  always_comb begin
    prev_d = key_i;
  end

  // Key history register
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      prev_q <= {WIDTH{1'b1}};
    end else begin
      prev_q <= prev_d;
    end
  end

  assign edge_o = key_i & ~prev_q;

endmodule

// File: rtl/dpc_run_control.sv
// -----------------------------------------------------------------------------
// dpc_run_control
// Run-control sequencer for the DekatronPC emulator. Turns front-panel key
// presses into a machine state, produces the counter reset pulses and issues
// single-instruction requests to the datapath over a req/ack handshake.
// Ports:
//   Clk, Rst_n        clock, asynchronous active-low reset
//   key_hard_rst      panel keys (levels, synchronised to Clk); only
//   key_soft_rst      rising edges are acted upon
//   key_halt
//   key_step
//   key_run
//   insn_ack          datapath finished the requested instruction
//   halt_insn         finished instruction was HALT (qualified by insn_ack)
//   insn_req          request one instruction (registered)
//   hard_rst_o        high while in DPC_HARD_RST
//   soft_rst_o        high while in DPC_SOFT_RST
//   state             current machine state encoding
// -----------------------------------------------------------------------------
module dpc_run_control
  import dpc_pkg::*;
#(
  parameter int unsigned HARD_RST_CYCLES = 4,
  parameter int unsigned SOFT_RST_CYCLES = 2
) (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic       key_hard_rst,
  input  logic       key_soft_rst,
  input  logic       key_halt,
  input  logic       key_step,
  input  logic       key_run,
  input  logic       insn_ack,
  input  logic       halt_insn,
  output logic       insn_req,
  output logic       hard_rst_o,
  output logic       soft_rst_o,
  output logic [2:0] state
);

  localparam int unsigned CNT_MAX = (HARD_RST_CYCLES > SOFT_RST_CYCLES) ?
                                    HARD_RST_CYCLES : SOFT_RST_CYCLES;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  // The counter holds "cycles remaining after this one", so it is loaded with N-1.
  localparam logic [CNT_W-1:0] HARD_LOAD = CNT_W'(HARD_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] SOFT_LOAD = CNT_W'(SOFT_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic [KEY_W-1:0] key_vec;
  logic [KEY_W-1:0] key_edges;
  dpc_event_t       key_ev;

  dpc_state_t       state_d,     state_q;
  logic [CNT_W-1:0] cnt_d,       cnt_q;
  logic             req_d,       req_q;
  logic             halt_pend_d, halt_pend_q;

  // Gather the panel keys into the shared vector layout
  always_comb begin
    key_vec               = {KEY_W{1'b0}};
    key_vec[KEY_HARD_RST] = key_hard_rst;
    key_vec[KEY_SOFT_RST] = key_soft_rst;
    key_vec[KEY_HALT]     = key_halt;
    key_vec[KEY_STEP]     = key_step;
    key_vec[KEY_RUN]      = key_run;
  end

  dpc_key_edge #(
    .WIDTH (KEY_W)
  ) u_key_edge (
    .Clk    (Clk),
    .Rst_n  (Rst_n),
    .key_i  (key_vec),
    .edge_o (key_edges)
  );

  // Next-state, counter, request and pending-halt logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_d       = req_q;
    halt_pend_d = halt_pend_q;
    key_ev      = dpc_pick_event(key_edges);

    case (state_q)
      DPC_HARD_RST: begin
        req_d       = 1'b0;
        halt_pend_d = 1'b0;
        if (key_ev == EV_HARD) begin
          cnt_d = HARD_LOAD;
        end else if (cnt_q == CNT_ZERO) begin
          state_d = DPC_HALT;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      DPC_SOFT_RST: begin
        req_d       = 1'b0;
        halt_pend_d = 1'b0;
        if (key_ev == EV_HARD) begin
          state_d = DPC_HARD_RST;
          cnt_d   = HARD_LOAD;
        end else if (cnt_q == CNT_ZERO) begin
          state_d = DPC_HALT;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      DPC_HALT: begin
        req_d       = 1'b0;
        halt_pend_d = 1'b0;
        case (key_ev)
          EV_HARD: begin
            state_d = DPC_HARD_RST;
            cnt_d   = HARD_LOAD;
          end
          EV_SOFT: begin
            state_d = DPC_SOFT_RST;
            cnt_d   = SOFT_LOAD;
          end
          // The request is raised together with the state change so it is
          // already high on the first cycle spent in STEP/RUN.
          EV_STEP: begin
            state_d = DPC_STEP;
            req_d   = 1'b1;
          end
          EV_RUN: begin
            state_d = DPC_RUN;
            req_d   = 1'b1;
          end
          default: begin
            state_d = DPC_HALT;
          end
        endcase
      end

      DPC_STEP: begin
        halt_pend_d = 1'b0;
        // A reset key beats a simultaneous ack: the instruction is cancelled.
        if (key_ev == EV_HARD) begin
          state_d = DPC_HARD_RST;
          cnt_d   = HARD_LOAD;
          req_d   = 1'b0;
        end else if (key_ev == EV_SOFT) begin
          state_d = DPC_SOFT_RST;
          cnt_d   = SOFT_LOAD;
          req_d   = 1'b0;
        end else if (req_q && insn_ack) begin
          state_d = DPC_HALT;
          req_d   = 1'b0;
        end else begin
          state_d = DPC_STEP;
        end
      end

      DPC_RUN: begin
        if (key_ev == EV_HARD) begin
          state_d     = DPC_HARD_RST;
          cnt_d       = HARD_LOAD;
          req_d       = 1'b0;
          halt_pend_d = 1'b0;
        end else if (key_ev == EV_SOFT) begin
          state_d     = DPC_SOFT_RST;
          cnt_d       = SOFT_LOAD;
          req_d       = 1'b0;
          halt_pend_d = 1'b0;
        end else if (req_q && insn_ack) begin
          // Dropping req for one cycle after every ack gives the gap
          // between consecutive instructions. A halt edge coinciding with
          // the ack counts as pending for this ack.
          req_d = 1'b0;
          if (halt_pend_q || (key_ev == EV_HALT) || halt_insn) begin
            state_d     = DPC_HALT;
            halt_pend_d = 1'b0;
          end else begin
            state_d     = DPC_RUN;
            halt_pend_d = 1'b0;
          end
        end else begin
          // Either still waiting for ack (req stays high) or in the gap
          // cycle (req re-asserts).
          req_d       = 1'b1;
          halt_pend_d = halt_pend_q || (key_ev == EV_HALT);
        end
      end

      default: begin
        state_d     = DPC_HARD_RST;
        cnt_d       = HARD_LOAD;
        req_d       = 1'b0;
        halt_pend_d = 1'b0;
      end
    endcase
  end

  // Sequencer state registers
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q     <= DPC_HARD_RST;
      cnt_q       <= HARD_LOAD;
      req_q       <= 1'b0;
      halt_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_q       <= req_d;
      halt_pend_q <= halt_pend_d;
    end
  end

  assign state      = state_q;
  assign insn_req   = req_q;
  assign hard_rst_o = (state_q == DPC_HARD_RST);
  assign soft_rst_o = (state_q == DPC_SOFT_RST);

endmodule

// File: tb/tb_dpc_run_control.sv
// -----------------------------------------------------------------------------
// tb_dpc_run_control
// Self-checking bench for dpc_run_control. A behavioural model steps on every
// clock edge and queues the expected outputs; a monitor pops and compares them
// on the falling edge. A datapath responder answers requests with a
// programmable or random latency. Directed scenarios are followed by a
// randomised key/ack phase.
// -----------------------------------------------------------------------------
module tb_dpc_run_control;

  localparam int HARD_N = 4;
  localparam int SOFT_N = 2;

  logic       Clk = 1'b0;
  logic       Rst_n = 1'b1;
  logic       key_hard_rst = 1'b0;
  logic       key_soft_rst = 1'b0;
  logic       key_halt = 1'b0;
  logic       key_step = 1'b0;
  logic       key_run = 1'b0;
  logic       insn_ack = 1'b0;
  logic       halt_insn = 1'b0;
  logic       insn_req;
  logic       hard_rst_o;
  logic       soft_rst_o;
  logic [2:0] state;

  always #5 Clk = ~Clk;

  dpc_run_control #(
    .HARD_RST_CYCLES (HARD_N),
    .SOFT_RST_CYCLES (SOFT_N)
  ) dut (
    .Clk          (Clk),
    .Rst_n        (Rst_n),
    .key_hard_rst (key_hard_rst),
    .key_soft_rst (key_soft_rst),
    .key_halt     (key_halt),
    .key_step     (key_step),
    .key_run      (key_run),
    .insn_ack     (insn_ack),
    .halt_insn    (halt_insn),
    .insn_req     (insn_req),
    .hard_rst_o   (hard_rst_o),
    .soft_rst_o   (soft_rst_o),
    .state        (state)
  );

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [2:0] st;
    logic       req;
    logic       hr;
    logic       sr;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  // ---------------- reference model ----------------
  // Machine modes as the panel describes them; mapped to output codes below.
  localparam int MODE_RESETTING  = 10;
  localparam int MODE_CLEARING   = 11;
  localparam int MODE_STOPPED    = 12;
  localparam int MODE_SINGLE     = 13;
  localparam int MODE_CONTINUOUS = 14;

  int       m_mode;
  int       m_left;      // cycles of reset output still to show, incl. this one
  bit       m_busy;      // an instruction request is outstanding
  bit       m_stop;      // operator asked to stop at the next completion
  bit [4:0] m_prev;      // {run, step, halt, soft, hard}
  bit [4:0] m_kv;
  bit [4:0] m_ev;
  int       m_top;       // 0 hard, 1 soft, 2 halt, 3 step, 4 run, -1 none

  function automatic logic [2:0] code_of(input int mode);
    case (mode)
      MODE_RESETTING:  return 3'b000;
      MODE_CLEARING:   return 3'b001;
      MODE_STOPPED:    return 3'b010;
      MODE_SINGLE:     return 3'b011;
      MODE_CONTINUOUS: return 3'b100;
      default:         return 3'b111;
    endcase
  endfunction

  always @(posedge Clk) begin
    if (!Rst_n) begin
      m_mode = MODE_RESETTING;
      m_left = HARD_N;
      m_busy = 1'b0;
      m_stop = 1'b0;
      m_prev = 5'b11111;
    end else begin
      m_kv   = {key_run, key_step, key_halt, key_soft_rst, key_hard_rst};
      m_ev   = m_kv & ~m_prev;
      m_prev = m_kv;
      m_top  = -1;
      for (int k = 4; k >= 0; k--) if (m_ev[k]) m_top = k;

      if ((m_mode == MODE_SINGLE || m_mode == MODE_CONTINUOUS) && (m_top == 0 || m_top == 1)) begin
        m_busy = 1'b0;
        m_stop = 1'b0;
        m_mode = (m_top == 0) ? MODE_RESETTING : MODE_CLEARING;
        m_left = (m_top == 0) ? HARD_N : SOFT_N;
      end else begin
        case (m_mode)
          MODE_RESETTING: begin
            if (m_top == 0) m_left = HARD_N;
            else begin
              m_left--;
              if (m_left == 0) m_mode = MODE_STOPPED;
            end
          end
          MODE_CLEARING: begin
            if (m_top == 0) begin
              m_mode = MODE_RESETTING;
              m_left = HARD_N;
            end else begin
              m_left--;
              if (m_left == 0) m_mode = MODE_STOPPED;
            end
          end
          MODE_STOPPED: begin
            if (m_top == 0) begin m_mode = MODE_RESETTING; m_left = HARD_N; end
            else if (m_top == 1) begin m_mode = MODE_CLEARING; m_left = SOFT_N; end
            else if (m_top == 3) begin m_mode = MODE_SINGLE; m_busy = 1'b1; end
            else if (m_top == 4) begin m_mode = MODE_CONTINUOUS; m_busy = 1'b1; end
          end
          MODE_SINGLE: begin
            if (m_busy && insn_ack) begin
              m_busy = 1'b0;
              m_mode = MODE_STOPPED;
            end
          end
          MODE_CONTINUOUS: begin
            if (m_top == 2) m_stop = 1'b1;
            if (m_busy && insn_ack) begin
              m_busy = 1'b0;
              if (m_stop || halt_insn) begin
                m_mode = MODE_STOPPED;
                m_stop = 1'b0;
              end
            end else if (!m_busy) begin
              m_busy = 1'b1;
            end
          end
          default: m_mode = MODE_RESETTING;
        endcase
      end
    end
    exp_q.push_back('{st: code_of(m_mode), req: m_busy,
                      hr: (m_mode == MODE_RESETTING), sr: (m_mode == MODE_CLEARING)});
  end

  // ---------------- monitor / scoreboard ----------------
  int   rises = 0;
  int   high_cyc = 0;
  logic prev_req = 1'b0;

  always @(negedge Clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      checks++;
      if ({state, insn_req, hard_rst_o, soft_rst_o} !== mon_e) begin
        errors++;
        $display("FAIL cycle_outputs t=%0t: got st=%b req=%b hr=%b sr=%b, expected st=%b req=%b hr=%b sr=%b",
                 $time, state, insn_req, hard_rst_o, soft_rst_o, mon_e.st, mon_e.req, mon_e.hr, mon_e.sr);
      end
    end
    if (insn_req === 1'b1 && prev_req !== 1'b1) rises++;
    if (insn_req === 1'b1) high_cyc++;
    prev_req = insn_req;
  end

  // ---------------- datapath responder ----------------
  int lat = 1;
  int rcnt = 0;
  int n_acks = 0;
  int halt_at = 0;
  bit rand_lat = 1'b0;
  bit rand_noise = 1'b0;
  bit spur_one = 1'b0;

  always @(negedge Clk) begin
    if (!Rst_n) begin
      insn_ack  = 1'b0;
      halt_insn = 1'b0;
      rcnt      = 0;
    end else if (insn_req === 1'b1) begin
      if (rcnt == lat) begin
        insn_ack  = 1'b1;
        n_acks++;
        halt_insn = ((halt_at != 0) && (n_acks == halt_at)) || (rand_noise && ($urandom_range(0, 5) == 0));
        rcnt      = 0;
        if (rand_lat) lat = $urandom_range(1, 4);
      end else begin
        insn_ack  = 1'b0;
        halt_insn = rand_noise && ($urandom_range(0, 2) == 0);
        rcnt++;
      end
    end else begin
      insn_ack  = spur_one || (rand_noise && ($urandom_range(0, 3) == 0));
      halt_insn = rand_noise && ($urandom_range(0, 2) == 0);
      spur_one  = 1'b0;
      rcnt      = 0;
    end
  end

  // ---------------- helpers ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge Clk);
    #3;
  endtask

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, input string name);
    int n;
    n = 0;
    while (state !== s && n < budget) begin
      cyc(1);
      n++;
    end
    checks++;
    if (state !== s) begin
      errors++;
      $display("FAIL %s: timed out with state=%b, expected %b", name, state, s);
    end
  endtask

  int r;

  // ---------------- stimulus ----------------
  initial begin
    #1 Rst_n = 1'b0;
    #1;
    chk("async_reset_state", int'(state), 0);
    chk("async_reset_hard", int'(hard_rst_o), 1);
    chk("async_reset_soft", int'(soft_rst_o), 0);
    chk("async_reset_req", int'(insn_req), 0);
    cyc(3);
    Rst_n = 1'b1;

    // Reset sequence: HARD_RST -> HALT, no request
    rises = 0;
    cyc(6);
    chk("boot_state_halt", int'(state), 2);
    chk("boot_no_req", rises, 0);

    // Single step, ack 3 cycles after request
    lat = 3; rises = 0; high_cyc = 0;
    key_step = 1'b1; cyc(1); key_step = 1'b0;
    cyc(10);
    chk("step_req_count", rises, 1);
    chk("step_req_high_cycles", high_cyc, 4);
    chk("step_back_to_halt", int'(state), 2);

    // Run with 1-cycle ack; 5th instruction is HALT
    lat = 1; halt_at = 5; n_acks = 0; rises = 0; high_cyc = 0;
    key_run = 1'b1; cyc(1); key_run = 1'b0;
    cyc(20);
    chk("run_req_count", rises, 5);
    chk("run_req_high_cycles", high_cyc, 10);
    chk("run_halt_insn_state", int'(state), 2);
    halt_at = 0;

    // Halt key while a request is outstanding
    lat = 6; rises = 0; high_cyc = 0;
    key_run = 1'b1; cyc(1); key_run = 1'b0;
    cyc(2);
    key_halt = 1'b1; cyc(1); key_halt = 1'b0;
    cyc(12);
    chk("halt_key_req_count", rises, 1);
    chk("halt_key_req_high", high_cyc, 7);
    chk("halt_key_state", int'(state), 2);

    // Soft + step edges together while running: soft wins, late ack ignored
    lat = 20; rises = 0;
    key_run = 1'b1; cyc(1); key_run = 1'b0;
    cyc(3);
    key_soft_rst = 1'b1; key_step = 1'b1; cyc(1);
    key_soft_rst = 1'b0; key_step = 1'b0;
    chk("abort_state_soft", int'(state), 1);
    chk("abort_req_low", int'(insn_req), 0);
    chk("abort_soft_out", int'(soft_rst_o), 1);
    spur_one = 1'b1;
    cyc(3);
    chk("abort_then_halt", int'(state), 2);
    chk("abort_req_count", rises, 1);

    // Run key held through reset does not start RUN
    key_run = 1'b1;
    Rst_n = 1'b0;
    cyc(2);
    Rst_n = 1'b1;
    cyc(8);
    chk("held_run_no_entry", int'(state), 2);
    key_run = 1'b0; cyc(1);
    lat = 2;
    key_run = 1'b1; cyc(1);
    chk("repress_run_entry", int'(state), 4);
    key_run = 1'b0;
    key_halt = 1'b1; cyc(1); key_halt = 1'b0;
    wait_state(3'b010, 50, "repress_run_halt");

    // Randomised keys, latencies, spurious ack / halt_insn, one mid-run reset
    rand_lat = 1'b1; rand_noise = 1'b1;
    for (int i = 0; i < 600; i++) begin
      if (i == 300) begin
        Rst_n = 1'b0;
        #1;
        chk("midop_reset_state", int'(state), 0);
        chk("midop_reset_req", int'(insn_req), 0);
        cyc(1);
        Rst_n = 1'b1;
      end
      if ($urandom_range(0, 9) == 0) begin
        r = $urandom_range(0, 31);
        if (r == 0)       key_hard_rst = ~key_hard_rst;
        else if (r < 3)   key_soft_rst = ~key_soft_rst;
        else if (r < 10)  key_halt     = ~key_halt;
        else if (r < 20)  key_step     = ~key_step;
        else              key_run      = ~key_run;
      end
      cyc(1);
    end

    key_hard_rst = 1'b0; key_soft_rst = 1'b0; key_halt = 1'b0;
    key_step = 1'b0; key_run = 1'b0;
    rand_noise = 1'b0; rand_lat = 1'b0; lat = 2;
    cyc(10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dpc_run_control.md
Name: dpc_run_control

Overview:
- Run-control sequencer for the DekatronPC emulator.
- Converts the front-panel keys (hard reset, soft reset, halt, step, run) into a machine state.
- Generates hard/soft reset pulses for the IP/loop/AP/data counters.
- Issues one-instruction-at-a-time execution requests to the datapath over a req/ack handshake; stops on a halt key or a datapath HALT instruction.

Parameters:
- HARD_RST_CYCLES, 4, clock cycles hard_rst_o is held in DPC_HARD_RST (>=1).
- SOFT_RST_CYCLES, 2, clock cycles soft_rst_o is held in DPC_SOFT_RST (>=1).

Ports:
- Clk  in  1  system clock.
- Rst_n  in  1  reset, asynchronous, active-low.
- key_hard_rst  in  1  panel key level, already synchronised to Clk.
- key_soft_rst  in  1  panel key level, synchronised.
- key_halt  in  1  panel key level, synchronised.
- key_step  in  1  panel key level, synchronised.
- key_run  in  1  panel key level, synchronised.
- insn_ack  in  1  datapath has completed the requested instruction.
- halt_insn  in  1  completed instruction was HALT; valid only with insn_ack.
- insn_req  out  1  request execution of one instruction.
- hard_rst_o  out  1  hard reset to all counters and memory.
- soft_rst_o  out  1  soft reset to IP/loop counters.
- state  out  3  current state: 000 HARD_RST, 001 SOFT_RST, 010 HALT, 011 STEP, 100 RUN.

Behaviour:
- Reset (Rst_n low):
  - state=HARD_RST, insn_req=0, soft_rst_o=0, hard_rst_o=1.
  - Cycle counter loaded with HARD_RST_CYCLES-1.
  - Key history registers set to all ones, so keys held through reset do not fire.
- Key events: rising edge only, key & ~prev, with prev registered each Clk.
- Priority when several key edges occur in one cycle: hard > soft > halt > step > run.
- Outputs: hard_rst_o = (state==HARD_RST) and soft_rst_o = (state==SOFT_RST), both decoded from the registered state. insn_req is a register.
- HARD_RST:
  - Counter decrements each cycle; at 0, go to HALT. hard_rst_o is therefore high for exactly HARD_RST_CYCLES cycles.
  - A hard edge reloads the counter. All other keys are ignored.
- SOFT_RST:
  - Same mechanism with SOFT_RST_CYCLES, then go to HALT.
  - A hard edge goes to HARD_RST. Other keys are ignored.
- HALT: hard edge -> HARD_RST; soft -> SOFT_RST; step -> STEP; run -> RUN; halt ignored.
- STEP:
  - On entry, insn_req rises on the first cycle in STEP.
  - When insn_ack is sampled high, insn_req=0 on the next cycle and state=HALT.
  - Halt, step and run edges are ignored.
- RUN:
  - insn_req asserts on entry. After ack is sampled, insn_req is low for exactly one cycle, then re-asserts.
  - Minimum instruction period is therefore 2 cycles plus datapath latency.
  - A halt edge sets halt_pending. At the next ack, go to HALT, clear halt_pending, and do not re-request.
  - insn_ack & halt_insn -> HALT, same as halt_pending.
  - Step and run edges are ignored.
- Handshake rules:
  - insn_req, once high, stays high until insn_ack is sampled.
  - insn_ack while insn_req is low is ignored.
  - halt_insn without insn_ack is ignored.
- Abort:
  - A hard or soft edge in STEP/RUN aborts immediately: insn_req=0 on the next cycle, state goes to HARD_RST/SOFT_RST, halt_pending is cleared.
  - The datapath treats either reset as cancelling the outstanding instruction.
- An ack arriving in the same cycle as an abort edge: the abort wins; the instruction is considered cancelled.
- Rst_n asserted mid-operation: immediate return to the reset values above, regardless of the handshake.
- Unused state encodings 101-111: go to HARD_RST on the next cycle.

Decomposition:
- Shared package dpc_pkg:
  - dpc_state_t enum (3-bit encodings above; shared with DekatronPC DPC_currentState).
  - Key index constants KEY_HARD_RST..KEY_RUN for a 5-bit key vector.
- Sub-module dpc_key_edge: parameterised width, registered prev with reset to all ones, outputs the edge vector. Instantiated once for the 5 keys.

Test Plan:
- Release Rst_n with no keys -> hard_rst_o high for 4 cycles, state 000 -> 010, insn_req stays 0.
- In HALT, pulse key_step; datapath acks 3 cycles after req -> exactly one insn_req high period (4 cycles), state returns to 010, no further req.
- Key_run with ack 1 cycle after each req, halt_insn with the 5th ack -> exactly 5 requests with a 1-cycle low gap between them, then state 010.
- In RUN, key_halt edge while req is outstanding -> req held until ack; state 010 the cycle after ack; no new req.
- In RUN with req high, key_soft_rst and key_step edges in the same cycle -> soft wins: insn_req 0 next cycle, soft_rst_o high 2 cycles, then HALT. A late ack during SOFT_RST is ignored.
- Hold key_run through Rst_n release -> no RUN entry. Release and re-press key_run after HARD_RST completes -> RUN entered.
